// File: rtl/score_tracker_n.sv
// Score tracker: binary and packed-BCD score, PLAY/OVER/WIN state, BCD high score.
// Optional leading-zero blank mask enabled by defining SCORE_TRACKER_N_LZB_EN.
module score_tracker_n #(
   parameter int DIGITS     = 3,
   parameter int WIDTH      = 8,
   parameter int MAX_SCORE  = 140,
   parameter int INIT_SCORE = 2
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  s_reset,
   input  logic                  goodColl,
   input  logic                  badColl,
   output logic [WIDTH-1:0]      current_score,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [4*DIGITS-1:0]   high_bcd,
   output logic                  isGameComplete,
   output logic                  isWin
`ifdef SCORE_TRACKER_N_LZB_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   typedef enum logic [1:0] {PLAY, OVER, WIN} state_t;

   // Constant conversion, used only to build the reset value.
   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      int r;
      r = v;
      to_bcd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         to_bcd[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endfunction

   function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
      logic carry;
      bcd_inc = v;
      carry   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               bcd_inc[4*i +: 4] = 4'd0;
            end else begin
               bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   endfunction

   localparam logic [4*DIGITS-1:0] INIT_BCD = to_bcd(INIT_SCORE);
   localparam logic [WIDTH-1:0]    INIT_BIN = WIDTH'(INIT_SCORE);
   localparam logic [WIDTH-1:0]    MAX_BIN  = WIDTH'(MAX_SCORE);

   state_t                state, nxt_state;
   logic [WIDTH-1:0]      high_score, nxt_high_score;
   logic [WIDTH-1:0]      nxt_score;
   logic [4*DIGITS-1:0]   nxt_bcd, nxt_high_bcd;

   always_comb begin
      nxt_state      = state;
      nxt_score      = current_score;
      nxt_bcd        = bcd;
      nxt_high_score = high_score;
      nxt_high_bcd   = high_bcd;
      if (state == PLAY) begin
         if (badColl) begin
            nxt_state = OVER;
         end else if (goodColl) begin
            nxt_score = current_score + 1'b1;
            nxt_bcd   = bcd_inc(bcd);
            if (nxt_score == MAX_BIN) nxt_state = WIN;
         end
         // High score is captured on the edge that leaves PLAY, using the final score.
         if (nxt_state != PLAY && nxt_score > high_score) begin
            nxt_high_score = nxt_score;
            nxt_high_bcd   = nxt_bcd;
         end
      end
   end

`ifdef SCORE_TRACKER_N_LZB_EN
   function automatic logic [DIGITS-1:0] lzb(input logic [4*DIGITS-1:0] v);
      logic all_zero;
      lzb      = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         all_zero = all_zero && (v[4*i +: 4] == 4'd0);
         lzb[i]   = all_zero;
      end
   endfunction

   // Mask is built from the next bcd so it lines up with the registered bcd.
   always_ff @(posedge clk) begin
      if (!nRst || s_reset) blank <= lzb(INIT_BCD);
      else                  blank <= lzb(nxt_bcd);
   end
`endif

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state          <= PLAY;
         current_score  <= INIT_BIN;
         bcd            <= INIT_BCD;
         high_score     <= '0;
         high_bcd       <= '0;
         isGameComplete <= 1'b0;
         isWin          <= 1'b0;
      end else if (s_reset) begin
         state          <= PLAY;
         current_score  <= INIT_BIN;
         bcd            <= INIT_BCD;
         isGameComplete <= 1'b0;
         isWin          <= 1'b0;
      end else begin
         state          <= nxt_state;
         current_score  <= nxt_score;
         bcd            <= nxt_bcd;
         high_score     <= nxt_high_score;
         high_bcd       <= nxt_high_bcd;
         isGameComplete <= (nxt_state != PLAY);
         isWin          <= (nxt_state == WIN);
      end
   end

endmodule

// File: tb/tb_score_tracker_n.sv
// Directed bench for score_tracker_n: reset, counting, BCD carries, loss/win and high score.
module tb_score_tracker_n;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        s_reset = 1'b0;
   logic        goodColl = 1'b0;
   logic        badColl = 1'b0;
   logic [7:0]  current_score;
   logic [11:0] bcd;
   logic [11:0] high_bcd;
   logic        isGameComplete;
   logic        isWin;
`ifdef SCORE_TRACKER_N_LZB_EN
   logic [2:0]  blank;
`endif

   int checks = 0;
   int errors = 0;

   score_tracker_n dut (
      .clk(clk), .nRst(nRst), .s_reset(s_reset),
      .goodColl(goodColl), .badColl(badColl),
      .current_score(current_score), .bcd(bcd), .high_bcd(high_bcd),
      .isGameComplete(isGameComplete), .isWin(isWin)
`ifdef SCORE_TRACKER_N_LZB_EN
      , .blank(blank)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_good(input int n);
      for (int i = 0; i < n; i++) begin
         goodColl = 1'b1;
         tick();
         goodColl = 1'b0;
      end
   endtask

   task automatic do_sreset();
      s_reset = 1'b1;
      tick();
      s_reset = 1'b0;
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      tick();
      tick();
      nRst = 1'b1;
      tick();
      checks++; if (current_score !== 8'd2) begin errors++; $display("FAIL reset_score got %0d want 2", current_score); end
      checks++; if (bcd !== 12'h002) begin errors++; $display("FAIL reset_bcd got %h want 002", bcd); end
      checks++; if (high_bcd !== 12'h000) begin errors++; $display("FAIL reset_high got %h want 000", high_bcd); end
      checks++; if (isGameComplete !== 1'b0 || isWin !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", isGameComplete, isWin); end
   endtask

   task automatic test_simultaneous();
      pulse_good(3);
      checks++; if (current_score !== 8'd5 || bcd !== 12'h005) begin errors++; $display("FAIL sim_pre got %0d/%h want 5/005", current_score, bcd); end
      goodColl = 1'b1; badColl = 1'b1;
      tick();
      goodColl = 1'b0; badColl = 1'b0;
      checks++; if (current_score !== 8'd5 || bcd !== 12'h005) begin errors++; $display("FAIL sim_score got %0d/%h want 5/005", current_score, bcd); end
      checks++; if (isGameComplete !== 1'b1 || isWin !== 1'b0) begin errors++; $display("FAIL sim_flags got %b%b want 10", isGameComplete, isWin); end
      checks++; if (high_bcd !== 12'h005) begin errors++; $display("FAIL sim_high got %h want 005", high_bcd); end
      pulse_good(2);
      badColl = 1'b1; tick(); badColl = 1'b0;
      checks++; if (current_score !== 8'd5 || isGameComplete !== 1'b1) begin errors++; $display("FAIL over_frozen got %0d/%b want 5/1", current_score, isGameComplete); end
      do_sreset();
      checks++; if (current_score !== 8'd2 || isGameComplete !== 1'b0 || high_bcd !== 12'h005) begin errors++; $display("FAIL sreset_over got %0d/%b/%h want 2/0/005", current_score, isGameComplete, high_bcd); end
   endtask

   task automatic test_count();
      logic [11:0] exp_bcd [8] = '{12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008, 12'h009, 12'h010};
      for (int i = 0; i < 8; i++) begin
         pulse_good(1);
         checks++; if (current_score !== 8'(3 + i) || bcd !== exp_bcd[i]) begin errors++; $display("FAIL count%0d got %0d/%h want %0d/%h", i, current_score, bcd, 3 + i, exp_bcd[i]); end
      end
`ifdef SCORE_TRACKER_N_LZB_EN
      checks++; if (blank !== 3'b100) begin errors++; $display("FAIL blank10 got %b want 100", blank); end
`endif
   endtask

   task automatic test_double_carry();
      pulse_good(89);
      checks++; if (current_score !== 8'd99 || bcd !== 12'h099) begin errors++; $display("FAIL pre99 got %0d/%h want 99/099", current_score, bcd); end
      pulse_good(1);
      checks++; if (current_score !== 8'd100 || bcd !== 12'h100) begin errors++; $display("FAIL carry100 got %0d/%h want 100/100", current_score, bcd); end
      checks++; if (isGameComplete !== 1'b0) begin errors++; $display("FAIL carry_play got %b want 0", isGameComplete); end
`ifdef SCORE_TRACKER_N_LZB_EN
      checks++; if (blank !== 3'b000) begin errors++; $display("FAIL blank100 got %b want 000", blank); end
`endif
   endtask

   task automatic test_win();
      pulse_good(39);
      checks++; if (current_score !== 8'd139 || bcd !== 12'h139 || isWin !== 1'b0) begin errors++; $display("FAIL pre139 got %0d/%h/%b want 139/139/0", current_score, bcd, isWin); end
      pulse_good(1);
      checks++; if (current_score !== 8'd140 || bcd !== 12'h140) begin errors++; $display("FAIL win_score got %0d/%h want 140/140", current_score, bcd); end
      checks++; if (isWin !== 1'b1 || isGameComplete !== 1'b1) begin errors++; $display("FAIL win_flags got %b%b want 11", isGameComplete, isWin); end
      checks++; if (high_bcd !== 12'h140) begin errors++; $display("FAIL win_high got %h want 140", high_bcd); end
      pulse_good(2);
      checks++; if (current_score !== 8'd140 || isWin !== 1'b1) begin errors++; $display("FAIL win_frozen got %0d/%b want 140/1", current_score, isWin); end
      do_sreset();
      checks++; if (current_score !== 8'd2 || bcd !== 12'h002 || isWin !== 1'b0 || isGameComplete !== 1'b0) begin errors++; $display("FAIL win_sreset got %0d/%h/%b%b want 2/002/00", current_score, bcd, isGameComplete, isWin); end
      checks++; if (high_bcd !== 12'h140) begin errors++; $display("FAIL win_high_kept got %h want 140", high_bcd); end
   endtask

   task automatic test_high_keep();
      nRst = 1'b0; tick(); nRst = 1'b1;
      checks++; if (high_bcd !== 12'h000) begin errors++; $display("FAIL nrst_high got %h want 000", high_bcd); end
      pulse_good(18);
      badColl = 1'b1; tick(); badColl = 1'b0;
      checks++; if (high_bcd !== 12'h020 || current_score !== 8'd20) begin errors++; $display("FAIL high20 got %h/%0d want 020/20", high_bcd, current_score); end
      do_sreset();
      pulse_good(5);
`ifdef SCORE_TRACKER_N_LZB_EN
      checks++; if (blank !== 3'b110) begin errors++; $display("FAIL blank7 got %b want 110", blank); end
`endif
      badColl = 1'b1; tick(); badColl = 1'b0;
      checks++; if (current_score !== 8'd7 || bcd !== 12'h007 || isGameComplete !== 1'b1) begin errors++; $display("FAIL over7 got %0d/%h/%b want 7/007/1", current_score, bcd, isGameComplete); end
      checks++; if (high_bcd !== 12'h020) begin errors++; $display("FAIL high_kept got %h want 020", high_bcd); end
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_count();
      test_double_carry();
      test_win();
      test_high_keep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
